// File: rtl/native_to_axis_video_pkg.sv
// Shared definitions for the native-to-AXI4-Stream video bridge: sync polarity
// names, FIFO entry tag layout and pointer sizing.
package native_to_axis_video_pkg;

  localparam string VS_POL_HIGH = "HIGH";
  localparam string VS_POL_LOW  = "LOW";

  // Per-pixel flags stored above the pixel data in each FIFO entry: {sof, eol, data}
  typedef struct packed {
    logic sof;
    logic eol;
  } vid_tag_t;

  localparam int TAG_W = $bits(vid_tag_t);

  // Address bits plus one wrap bit to tell full from empty
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; a write while full is accepted
// only when a read happens in the same cycle.
module sync_fwft_fifo
  import native_to_axis_video_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/native_to_axis_video.sv
// Native vsync/de pixel bus to AXI4-Stream video (tuser = SOF, tlast = EOL),
// with a small stall FIFO, sticky overflow and per-frame geometry checking.
module native_to_axis_video
  import native_to_axis_video_pkg::*;
#(
  parameter int    DSIZE      = 24,
  parameter int    FIFO_DEPTH = 16,
  parameter string VS_POL     = VS_POL_HIGH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      hactive,
  input  logic [15:0]      vactive,
  input  logic             vsync,
  input  logic             hsync,
  input  logic             de,
  input  logic [DSIZE-1:0] idata,
  output logic [DSIZE-1:0] axis_tdata,
  output logic             axis_tvalid,
  input  logic             axis_tready,
  output logic             axis_tuser,
  output logic             axis_tlast,
  output logic             overflow,
  output logic             frame_err,
  output logic [15:0]      line_cnt
);

  localparam bit VS_HIGH = (VS_POL != VS_POL_LOW);
  localparam int EW      = DSIZE + TAG_W;

  logic             vs_act;
  logic             vs_d;
  logic             frame_start;
  logic             vld_p0;
  logic [DSIZE-1:0] data_p0;
  logic             vld_p1;
  vid_tag_t         tag_p1;
  logic [DSIZE-1:0] data_p1;
  logic             sof_arm;
  logic             seen_frame;
  logic             line_err;
  logic [15:0]      h_exp;
  logic [15:0]      v_exp;
  logic [15:0]      pix_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [EW-1:0]    fifo_dout;
  vid_tag_t         head_tag;
  logic             unused_hsync;

  // Line ends come from de falling, so hsync carries no information here
  assign unused_hsync = hsync;

  assign vs_act      = VS_HIGH ? vsync : ~vsync;
  assign frame_start = vs_act & ~vs_d;
  assign pop         = ~fifo_empty & axis_tready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vs_d       <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      sof_arm    <= 1'b0;
      seen_frame <= 1'b0;
      line_err   <= 1'b0;
      h_exp      <= '0;
      v_exp      <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vs_d      <= vs_act;
      frame_err <= 1'b0;
      // p0 -> p1: the held pixel is pushed; de low now means it closed the line
      vld_p0    <= de;
      vld_p1    <= vld_p0;
      if (vld_p0) begin
        tag_p1.sof <= sof_arm;
        tag_p1.eol <= ~de;
        sof_arm    <= 1'b0;
        if (!de) begin
          pix_cnt <= '0;
          if (pix_cnt + 16'd1 != h_exp) line_err <= 1'b1;
          if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
        end else begin
          pix_cnt <= pix_cnt + 16'd1;
        end
      end
      // p1 -> FIFO
      if (vld_p1 && fifo_full && !pop) overflow <= 1'b1;
      // Frame start overrides same-cycle counter updates; the in-flight push keeps the old SOF
      if (frame_start) begin
        sof_arm    <= 1'b1;
        h_exp      <= hactive;
        v_exp      <= vactive;
        seen_frame <= 1'b1;
        frame_err  <= seen_frame && ((line_cnt != v_exp) || line_err);
        line_cnt   <= '0;
        line_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (de)     data_p0 <= idata;
    if (vld_p0) data_p1 <= data_p0;
  end

  sync_fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (vld_p1),
    .din   ({tag_p1, data_p1}),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Head is masked while empty so the stream reads all-zero when idle
  assign head_tag    = fifo_dout[EW-1:DSIZE];
  assign axis_tvalid = ~fifo_empty;
  assign axis_tuser  = ~fifo_empty & head_tag.sof;
  assign axis_tlast  = ~fifo_empty & head_tag.eol;
  assign axis_tdata  = fifo_empty ? '0 : fifo_dout[DSIZE-1:0];

endmodule

// File: tb/tb_native_to_axis_video.sv
// Scoreboard bench: a HIGH-polarity and a LOW-polarity instance share all
// stimulus (the LOW one sees inverted vsync) and are checked against one model.
module tb_native_to_axis_video;

  logic        clock = 1'b0;
  logic        rst;
  logic        vs;
  logic        hsync;
  logic        de;
  logic [23:0] idata;
  logic        axis_tready;
  logic [15:0] hactive;
  logic [15:0] vactive;

  logic [23:0] h_tdata, l_tdata;
  logic        h_tvalid, l_tvalid, h_tuser, l_tuser, h_tlast, l_tlast;
  logic        h_overflow, l_overflow, h_frame_err, l_frame_err;
  logic [15:0] h_line_cnt, l_line_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [25:0] q_h[$];
  logic [25:0] q_l[$];
  int          q_limit;
  bit          sof_arm, m_seen, m_lerr;
  int          m_lines, m_hexp, m_vexp;
  bit          stall_h, stall_l;
  logic [25:0] held_h, held_l;

  always #5 clock = ~clock;

  native_to_axis_video #(.DSIZE(24), .FIFO_DEPTH(16), .VS_POL("HIGH")) dut_h (
    .clock(clock), .rst(rst), .hactive(hactive), .vactive(vactive),
    .vsync(vs), .hsync(hsync), .de(de), .idata(idata),
    .axis_tdata(h_tdata), .axis_tvalid(h_tvalid), .axis_tready(axis_tready),
    .axis_tuser(h_tuser), .axis_tlast(h_tlast), .overflow(h_overflow),
    .frame_err(h_frame_err), .line_cnt(h_line_cnt)
  );

  native_to_axis_video #(.DSIZE(24), .FIFO_DEPTH(16), .VS_POL("LOW")) dut_l (
    .clock(clock), .rst(rst), .hactive(hactive), .vactive(vactive),
    .vsync(~vs), .hsync(hsync), .de(de), .idata(idata),
    .axis_tdata(l_tdata), .axis_tvalid(l_tvalid), .axis_tready(axis_tready),
    .axis_tuser(l_tuser), .axis_tlast(l_tlast), .overflow(l_overflow),
    .frame_err(l_frame_err), .line_cnt(l_line_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mon(input int idx, input logic tv, input logic [25:0] b,
                     inout bit stall, inout logic [25:0] held);
    logic [25:0] e;
    if (stall) check(idx == 0 ? "hi_stall_hold" : "lo_stall_hold", {tv, b}, {1'b1, held});
    if (tv && axis_tready) begin
      if ((idx == 0 ? q_h.size() : q_l.size()) == 0) begin
        check(idx == 0 ? "hi_extra_beat" : "lo_extra_beat", {6'd0, b}, 32'hFFFF_FFFF);
      end else begin
        e = (idx == 0) ? q_h.pop_front() : q_l.pop_front();
        check(idx == 0 ? "hi_beat" : "lo_beat", {6'd0, b}, {6'd0, e});
      end
    end
    stall = tv && !axis_tready;
    held  = b;
  endtask

  always @(negedge clock) begin
    if (rst) begin
      stall_h = 1'b0;
      stall_l = 1'b0;
    end else begin
      mon(0, h_tvalid, {h_tuser, h_tlast, h_tdata}, stall_h, held_h);
      mon(1, l_tvalid, {l_tuser, l_tlast, l_tdata}, stall_l, held_l);
    end
  end

  task automatic vs_pulse();
    bit exp_err;
    exp_err = m_seen && ((m_lines != m_vexp) || m_lerr);
    check("hi_line_cnt_pre", h_line_cnt, m_lines);
    check("lo_line_cnt_pre", l_line_cnt, m_lines);
    vs = 1'b1;
    tick();
    check("hi_frame_err", h_frame_err, exp_err);
    check("lo_frame_err", l_frame_err, exp_err);
    check("hi_line_cnt_post", h_line_cnt, 0);
    check("lo_line_cnt_post", l_line_cnt, 0);
    m_seen = 1'b1; m_hexp = hactive; m_vexp = vactive;
    sof_arm = 1'b1; m_lines = 0; m_lerr = 1'b0;
    vs = 1'b0;
    tick();
    check("hi_frame_err_end", h_frame_err, 0);
    check("lo_frame_err_end", l_frame_err, 0);
  endtask

  task automatic send_line(input int n, input int base, input bit lat);
    logic [25:0] ent;
    for (int i = 0; i < n; i++) begin
      de    = 1'b1;
      idata = 24'(base + i);
      ent   = {sof_arm, (i == n - 1), 24'(base + i)};
      sof_arm = 1'b0;
      if (q_h.size() < q_limit) begin
        q_h.push_back(ent);
        q_l.push_back(ent);
      end
      tick();
      if (lat && i < 3) begin
        check("hi_latency", h_tvalid, (i >= 2));
        check("lo_latency", l_tvalid, (i >= 2));
      end
    end
    de = 1'b0;
    tick();
    tick();
    m_lines++;
    if (n != m_hexp) m_lerr = 1'b1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && (q_h.size() + q_l.size()) != 0; k++) tick();
    check("drain", q_h.size() + q_l.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vs = 1'b0; hsync = 1'b0; de = 1'b0; idata = '0;
    axis_tready = 1'b1; hactive = 16'd4; vactive = 16'd2; q_limit = 1000;
    sof_arm = 1'b0; m_seen = 1'b0; m_lerr = 1'b0; m_lines = 0; m_hexp = 0; m_vexp = 0;
    tick();
    tick();
    check("hi_reset", {h_tvalid, h_tuser, h_tlast, h_overflow, h_frame_err, h_line_cnt, h_tdata != 0}, 0);
    check("lo_reset", {l_tvalid, l_tuser, l_tlast, l_overflow, l_frame_err, l_line_cnt, l_tdata != 0}, 0);
    rst = 1'b0;
    tick();

    // basic frame
    vs_pulse();
    send_line(4, 'h01, 1'b1);
    send_line(4, 'h05, 1'b0);
    wait_drain();
    vs_pulse();

    // backpressure
    axis_tready = 1'b0;
    send_line(4, 'h11, 1'b0);
    send_line(4, 'h15, 1'b0);
    repeat (10) tick();
    check("hi_bp_overflow", h_overflow, 0);
    check("lo_bp_overflow", l_overflow, 0);
    axis_tready = 1'b1;
    wait_drain();
    vs_pulse();

    // geometry error: short second line
    send_line(4, 'h21, 1'b0);
    send_line(3, 'h25, 1'b0);
    wait_drain();
    vs_pulse();

    // one-pixel lines, first carries SOF and EOL together
    send_line(1, 'h31, 1'b0);
    send_line(4, 'h32, 1'b0);
    send_line(1, 'h36, 1'b0);
    wait_drain();
    vs_pulse();

    // overflow
    axis_tready = 1'b0;
    q_limit = 16;
    send_line(20, 'h40, 1'b0);
    check("hi_overflow_set", h_overflow, 1);
    check("lo_overflow_set", l_overflow, 1);
    repeat (5) tick();
    axis_tready = 1'b1;
    wait_drain();
    repeat (5) tick();
    check("hi_overflow_sticky", h_overflow, 1);
    check("lo_overflow_sticky", l_overflow, 1);
    q_limit = 1000;

    // reset mid-line
    axis_tready = 1'b0;
    de = 1'b1; idata = 24'h51;
    tick();
    idata = 24'h52;
    tick();
    de = 1'b0;
    rst = 1'b1;
    #1;
    check("hi_tvalid_in_rst", h_tvalid, 0);
    check("lo_tvalid_in_rst", l_tvalid, 0);
    tick();
    rst = 1'b0;
    q_h.delete(); q_l.delete();
    sof_arm = 1'b0; m_seen = 1'b0; m_lines = 0; m_lerr = 1'b0; m_hexp = 0;
    check("hi_tvalid_after_rst", h_tvalid, 0);
    check("lo_tvalid_after_rst", l_tvalid, 0);
    check("hi_overflow_after_rst", h_overflow, 0);
    check("lo_overflow_after_rst", l_overflow, 0);
    axis_tready = 1'b1;
    send_line(2, 'h53, 1'b0);
    wait_drain();
    check("hi_idle_end", {h_tvalid, h_overflow}, 0);
    check("lo_idle_end", {l_tvalid, l_overflow}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/native_to_axis_video.md
Name: native_to_axis_video

Overview:
- Converts a native pixel bus (vsync/hsync/de/data) into an AXI4-Stream video stream with SOF on tuser and EOL on tlast.
- Sits directly upstream of the VDMA write port and drives its axis_in stream when IN_DATA_TYPE is AXIS.
- Absorbs short tready stalls in a small FIFO.
- Reports overflow and frame-geometry errors against the programmed hactive/vactive.

Parameters:
DSIZE, 24, pixel width in bits
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4
VS_POL, "HIGH", vsync active level ("HIGH"/"LOW")

Ports:
clock  in  1  pixel clock; the only clock
rst  in  1  asynchronous reset, active-high
hactive  in  16  expected pixels per line; sampled at each frame start
vactive  in  16  expected lines per frame; sampled at each frame start
vsync  in  1  native vertical sync, polarity per VS_POL
hsync  in  1  native horizontal sync; ignored, line ends are taken from de
de  in  1  data enable
idata  in  DSIZE  pixel data, valid when de=1
axis_tdata  out  DSIZE  stream pixel
axis_tvalid  out  1  stream valid
axis_tready  in  1  stream ready
axis_tuser  out  1  start of frame; first pixel of a frame
axis_tlast  out  1  end of line; last pixel of a line
overflow  out  1  sticky; a pixel was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse at frame start when the previous frame's geometry mismatched
line_cnt  out  16  lines completed in the current frame

Behaviour:
- Reset values: all outputs 0; FIFO empty; hold register invalid; SOF flag armed=0.
- vs_act = (VS_POL=="HIGH") ? vsync : ~vsync.
- Frame start is the rising edge of vs_act, detected with a 1-cycle register. At frame start:
  - arm the SOF flag;
  - latch hactive and vactive into h_exp and v_exp;
  - evaluate the previous frame: frame_err=1 for one cycle if line_cnt!=v_exp(old) or line_err is set;
  - then clear line_cnt and line_err.
  - No frame_err is evaluated on the first frame start after reset.
- Hold register: captures {idata} on every clock edge where de=1. On the next edge the held pixel is pushed into the FIFO as {sof, eol, data}.
  - eol = ~de at that edge, i.e. the line ended.
  - sof = SOF flag. The flag clears on that push.
  - If de stays high, the new pixel replaces the held one in the same cycle (back-to-back).
- Pixel counter pix_cnt (16 bit):
  - increments on each push;
  - resets to 0 after an eol push;
  - on an eol push with pix_cnt+1 != h_exp, set line_err;
  - on each eol push, line_cnt += 1, saturating at 16'hFFFF.
- FIFO:
  - first-word-fall-through; width DSIZE+2; pointers are log2(FIFO_DEPTH)+1 bits wide with wrap bit.
  - full: push is dropped and overflow sets. overflow stays set until rst.
  - full with a simultaneous pop: the push is accepted.
  - empty with a simultaneous push: axis_tvalid rises the next cycle; no pass-through in the same cycle.
- Output side:
  - axis_tvalid = ~empty; {axis_tuser, axis_tlast, axis_tdata} = FIFO head.
  - A pop occurs when tvalid&tready.
  - While tvalid=1 and tready=0, data and flags stay stable.
- Latency: a pixel sampled with de at edge k is pushed at edge k+1 and is visible on axis_tvalid after edge k+2, provided the FIFO was empty.
- vsync rising while a pixel is held (de low too early): the pending push uses the old SOF flag. The new SOF flag applies only to later pixels.
- A one-pixel line (single de cycle) is pushed with eol=1.
- Line boundary with SOF: if a line's first pixel carries SOF, tuser=1 and, for a 1-pixel line, tlast=1 in the same beat.
- rst mid-frame: everything returns to reset values immediately. The first frame after reset has no tuser until the next vsync edge.

Decomposition:
- The shared video package holds:
  - the FIFO entry typedef (struct: sof, eol, data[DSIZE]);
  - the VS_POL string constants;
  - a clog2-based pointer-width function.
- One sub-module, sync_fwft_fifo (parameters WIDTH, DEPTH), with ports clock, rst, push, din, full, pop, dout, empty.
- The top level holds edge detection, the hold register, the counters and error logic.

Test Plan:
- Basic frame:
  - Stimulus: hactive=4, vactive=2, VS_POL HIGH; vsync pulse, then 2 lines of 4 de pixels 0x01..0x08; tready=1.
  - Required: 8 beats; beat 0 tuser=1; tlast on beats 3 and 7; no frame_err at the next vsync.
  - Latency: first tvalid 2 cycles after the first de.
- Backpressure:
  - Stimulus: same frame with tready=0 for 10 cycles, then 1; FIFO_DEPTH=16.
  - Required: all 8 beats delivered in order; data held stable during the stall; overflow=0.
- Overflow:
  - Stimulus: tready=0, one line of 20 pixels, FIFO_DEPTH=16.
  - Required: overflow=1 and stays 1; after tready=1 exactly 16 beats come out; the last delivered beat has tlast=0.
- Geometry error:
  - Stimulus: hactive=4; send lines of 4 and 3 pixels; then vsync.
  - Required: frame_err pulses for exactly 1 cycle at the vsync edge; line_cnt reads 2 before it, 0 after.
- Edge cases:
  - Stimulus: VS_POL="LOW" with vsync falling edges; include a 1-pixel line.
  - Required: tuser on the first pixel only; the 1-pixel line emits tlast=1 on its single beat.
- Reset mid-line:
  - Stimulus: rst for 1 cycle after 2 of 4 pixels, then resume the same line without vsync.
  - Required: tvalid=0 during and after rst; later pixels have tuser=0; overflow=0.
